// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the push-button peripheral.
// Holds the register offsets decoded from address[3:2], the ID word and the
// bit layout of the EVENTS register.
package button_event_ctrl_pkg;

  localparam logic [1:0] BTN_REG_STATE  = 2'd0;
  localparam logic [1:0] BTN_REG_EVENTS = 2'd1;
  localparam logic [1:0] BTN_REG_COUNT  = 2'd2;
  localparam logic [1:0] BTN_REG_ID     = 2'd3;

  localparam logic [31:0] BTN_ID = 32'h4254_4E31;

  localparam int EVT_PRESS_LSB   = 0;
  localparam int EVT_RELEASE_LSB = 8;
  localparam int EVT_LONG_LSB    = 16;

  // Latched event bits, index 0 = btn1, index 1 = btn2.
  typedef struct packed {
    logic [1:0] lng;
    logic [1:0] rel;
    logic [1:0] press;
  } evt_t;

  function automatic logic [31:0] evt_word(input evt_t e);
    logic [31:0] w;
    w = '0;
    w[EVT_PRESS_LSB +: 2]   = e.press;
    w[EVT_RELEASE_LSB +: 2] = e.rel;
    w[EVT_LONG_LSB +: 2]    = e.lng;
    return w;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// CPU read-bus side of the push-button peripheral.
//   ren      : one-cycle read strobe from the bus decoder
//   address  : CPU data address, only [3:2] is decoded
//   data_out : registered read data
//   irq      : level interrupt, high while any event bit is pending
interface button_event_ctrl_if;
  logic        ren;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        irq;

  modport master (output ren, address, input data_out, irq);
  modport slave  (input ren, address, output data_out, irq);
endinterface

// File: rtl/button_event_ctrl_debounce.sv
// One button channel: 2-flop synchroniser, debounce timer and edge pulses.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   btn_i      : raw active-low button, asynchronous
//   level_o    : debounced level, 1 = pressed
//   press_o    : one-cycle pulse on debounced 0->1
//   release_o  : one-cycle pulse on debounced 1->0
module button_event_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, press_q, release_q;
  logic [CW-1:0] cnt_q;
  logic          pressed;

  assign pressed = ~sync_q[1];

  // Down-counter reloaded whenever the input agrees with the debounced level;
  // reaching zero means DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 2'b11;
      level_q   <= 1'b0;
      cnt_q     <= TC;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (pressed == level_q) begin
        cnt_q <= TC;
      end else if (cnt_q == '0) begin
        level_q   <= ~level_q;
        cnt_q     <= TC;
        press_q   <= ~level_q;
        release_q <= level_q;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Memory-mapped push-button peripheral: debounces two buttons, latches
// press/release events, counts presses and serves a registered read word.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   btn1, btn2 : raw active-low buttons
//   bus        : read bus (ren, address, data_out, irq)
// Build option: define BTN_LONGPRESS_EN to add per-button long-press events
// in EVENTS[17:16]; otherwise those bits read 0.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 65535,
  parameter int CNT_WIDTH        = 8,
  parameter int LONGPRESS_CYCLES = 13500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn1,
  input  logic                btn2,
  button_event_ctrl_if.slave  bus
);

  logic [1:0] level, press, rel, lp_fire;

  button_event_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk(clk), .reset(reset), .btn_i(btn1),
    .level_o(level[0]), .press_o(press[0]), .release_o(rel[0])
  );

  button_event_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clk(clk), .reset(reset), .btn_i(btn2),
    .level_o(level[1]), .press_o(press[1]), .release_o(rel[1])
  );

`ifdef BTN_LONGPRESS_EN
  localparam int LW = (LONGPRESS_CYCLES > 1) ? $clog2(LONGPRESS_CYCLES) : 1;
  localparam logic [LW-1:0] LTC = LW'(LONGPRESS_CYCLES - 1);

  logic [1:0][LW-1:0] hold_q;
  logic [1:0]         fired_q;

  // fired_q keeps the event to one per hold once the timer sits at zero.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      lp_fire[i] = level[i] && (hold_q[i] == '0) && !fired_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q  <= {2{LTC}};
      fired_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!level[i]) begin
          hold_q[i]  <= LTC;
          fired_q[i] <= 1'b0;
        end else begin
          if (hold_q[i] != '0) hold_q[i] <= hold_q[i] - 1'b1;
          if (lp_fire[i]) fired_q[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign lp_fire = 2'b00;
`endif

  evt_t                      evt_q, evt_d;
  logic [1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]               data_out_q, rd_word;
  logic                      irq_q, clr_evt, clr_cnt;
  logic [1:0]                rd_sel;
  logic                      unused_addr;

  assign rd_sel      = bus.address[3:2];
  assign unused_addr = ^{bus.address[31:4], bus.address[1:0]};

  always_comb begin
    clr_evt = bus.ren && (rd_sel == BTN_REG_EVENTS);
    clr_cnt = bus.ren && (rd_sel == BTN_REG_COUNT);

    // Clear first, then OR in new events so a same-edge event survives the read.
    evt_d       = clr_evt ? '0 : evt_q;
    evt_d.press = evt_d.press | press;
    evt_d.rel   = evt_d.rel | rel;
    evt_d.lng   = evt_d.lng | lp_fire;

    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = clr_cnt ? '0 : cnt_q[i];
      if (press[i] && !(&cnt_d[i])) cnt_d[i] = cnt_d[i] + 1'b1;
    end

    rd_word = '0;
    case (rd_sel)
      BTN_REG_STATE:  rd_word[1:0] = level;
      BTN_REG_EVENTS: rd_word = evt_word(evt_q);
      BTN_REG_COUNT: begin
        rd_word[CNT_WIDTH-1:0]   = cnt_q[0];
        rd_word[16 +: CNT_WIDTH] = cnt_q[1];
      end
      default:        rd_word = BTN_ID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q      <= '0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      evt_q <= evt_d;
      cnt_q <= cnt_d;
      irq_q <= |evt_d;
      if (bus.ren) data_out_q <= rd_word;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;

  localparam logic [31:0] A_STATE  = 32'h0000_0000;
  localparam logic [31:0] A_EVENTS = 32'h0000_0004;
  localparam logic [31:0] A_COUNT  = 32'h0000_0008;
  localparam logic [31:0] A_ID     = 32'h0000_000C;
`ifdef BTN_LONGPRESS_EN
  localparam logic [31:0] LP_BIT = 32'h0001_0000;
`else
  localparam logic [31:0] LP_BIT = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic reset, btn1, btn2;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] want;

  button_event_ctrl_if bus();

  button_event_ctrl #(
    .DEBOUNCE_CYCLES(16), .CNT_WIDTH(8), .LONGPRESS_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .bus(bus)
  );

  always #5 clk = ~clk;

  // All tasks start and end just after a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a one-cycle read and queues its expected word; data_out is valid
  // when the task returns.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp);
    bus.ren     = 1'b1;
    bus.address = addr;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.ren = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn1 = 1'b1; btn2 = 1'b1;
    bus.ren = 1'b0; bus.address = '0;
    @(negedge clk);
    cycles(3);
    reset = 1'b0;
    cycles(2);
    vectors++;
    if (bus.data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want %h", bus.data_out, 32'h0); end
    vectors++;
    if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    do_read(A_ID, 32'h4254_4E31);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL id_read: got %h want %h", bus.data_out, want); end
    do_read(32'hFFFF_FFF0, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL reset_state: got %h want %h", bus.data_out, want); end
    do_read(A_EVENTS, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL reset_events: got %h want %h", bus.data_out, want); end
  endtask

  task automatic test_glitch();
    btn1 = 1'b0; cycles(10);
    btn1 = 1'b1; cycles(40);
    do_read(A_STATE, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL glitch_state: got %h want %h", bus.data_out, want); end
    do_read(A_EVENTS, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL glitch_events: got %h want %h", bus.data_out, want); end
  endtask

  task automatic test_press_release();
    btn1 = 1'b0; cycles(30);
    do_read(A_STATE, 32'h1);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL held_state: got %h want %h", bus.data_out, want); end
    cycles(9);
    btn1 = 1'b1; cycles(40);
    vectors++;
    if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL irq_pending: got %b want 1", bus.irq); end
    do_read(A_EVENTS, 32'h0000_0101);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL pr_events: got %h want %h", bus.data_out, want); end
    vectors++;
    if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL irq_cleared: got %b want 0", bus.irq); end
    do_read(A_EVENTS, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL pr_events_rc: got %h want %h", bus.data_out, want); end
    do_read(A_STATE, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL released_state: got %h want %h", bus.data_out, want); end
    do_read(A_COUNT, 32'h0000_0001);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL pr_count: got %h want %h", bus.data_out, want); end
    do_read(A_COUNT, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL pr_count_rc: got %h want %h", bus.data_out, want); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      btn2 = 1'b0; cycles(20);
      btn2 = 1'b1; cycles(20);
    end
    do_read(A_COUNT, 32'h00FF_0000);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL sat_count: got %h want %h", bus.data_out, want); end
    do_read(A_COUNT, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL sat_count_rc: got %h want %h", bus.data_out, want); end
    do_read(A_EVENTS, 32'h0000_0202);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL sat_events: got %h want %h", bus.data_out, want); end
  endtask

  // btn1 falls before edge 1; synchroniser output settles at edge 2, the
  // debounced level rises at edge 18 and the press bit latches at edge 19,
  // which is the edge that samples the EVENTS read.
  task automatic test_back_to_back();
    btn1 = 1'b0;
    cycles(18);
    do_read(A_EVENTS, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL same_edge_old: got %h want %h", bus.data_out, want); end
    vectors++;
    if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL same_edge_irq: got %b want 1", bus.irq); end
    do_read(A_EVENTS, 32'h0000_0001);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL same_edge_kept: got %h want %h", bus.data_out, want); end
    btn1 = 1'b1; cycles(40);
    do_read(A_COUNT, 32'h0000_0001);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL same_edge_count: got %h want %h", bus.data_out, want); end
    do_read(A_EVENTS, 32'h0000_0100);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL same_edge_rel: got %h want %h", bus.data_out, want); end
  endtask

  task automatic test_reset_during_debounce();
    btn1 = 1'b0; cycles(10);
    reset = 1'b1; cycles(2);
    reset = 1'b0; cycles(10);
    do_read(A_STATE, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL rst_partial_state: got %h want %h", bus.data_out, want); end
    cycles(20);
    do_read(A_STATE, 32'h1);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL rst_held_state: got %h want %h", bus.data_out, want); end
    btn1 = 1'b1; cycles(40);
    do_read(A_EVENTS, 32'h0000_0101);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL rst_held_events: got %h want %h", bus.data_out, want); end
    do_read(A_COUNT, 32'h0000_0001);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL rst_held_count: got %h want %h", bus.data_out, want); end
  endtask

  task automatic test_simultaneous();
    btn1 = 1'b0; btn2 = 1'b0; cycles(30);
    btn1 = 1'b1; btn2 = 1'b1; cycles(40);
    do_read(A_EVENTS, 32'h0000_0303);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL simul_events: got %h want %h", bus.data_out, want); end
    do_read(A_COUNT, 32'h0001_0001);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL simul_count: got %h want %h", bus.data_out, want); end
  endtask

  task automatic test_longpress();
    btn1 = 1'b0; cycles(150);
    do_read(A_EVENTS, 32'h0000_0001 | LP_BIT);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL lp_first: got %h want %h", bus.data_out, want); end
    cycles(80);
    do_read(A_EVENTS, 32'h0);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL lp_once: got %h want %h", bus.data_out, want); end
    cycles(18);
    btn1 = 1'b1; cycles(40);
    do_read(A_EVENTS, 32'h0000_0100);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL lp_release: got %h want %h", bus.data_out, want); end
    do_read(A_COUNT, 32'h0000_0001);
    want = exp_q.pop_front(); vectors++;
    if (bus.data_out !== want) begin miscompares++; $display("FAIL lp_count: got %h want %h", bus.data_out, want); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press_release();
    test_saturation();
    test_back_to_back();
    test_reset_during_debounce();
    test_simultaneous();
    test_longpress();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
